// File: rtl/mips_mc_controller.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// for lw, sw, R-type, beq, addi and j. Define MIPS_MC_BNE_EN to also decode bne.
module mips_mc_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       memready,
  output logic       memreq,
  output logic       pcen,
  output logic       iord,
  output logic       irwrite,
  output logic       memwrite,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic [3:0] state,
  output logic       illegal
);

  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADR  = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_EXECUTE = 4'd6;
  localparam logic [3:0] S_ALUWB   = 4'd7;
  localparam logic [3:0] S_BRANCH  = 4'd8;
  localparam logic [3:0] S_ADDIEX  = 4'd9;
  localparam logic [3:0] S_ADDIWB  = 4'd10;
  localparam logic [3:0] S_JUMP    = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MIPS_MC_BNE_EN
  localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  logic [3:0] state_q, state_d;
  logic       illegal_q, illegal_d;
  logic [2:0] funct_ac;
  logic       funct_ok;

  always_comb begin
    funct_ac = 3'b000;
    funct_ok = 1'b1;
    case (funct)
      6'b100000: funct_ac = ALU_ADD;
      6'b100010: funct_ac = ALU_SUB;
      6'b100100: funct_ac = ALU_AND;
      6'b100101: funct_ac = ALU_OR;
      6'b101010: funct_ac = ALU_SLT;
      default:   funct_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    case (state_q)
      S_FETCH:  if (memready) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
`ifdef MIPS_MC_BNE_EN
          OP_BNE:       state_d = S_BRANCH;
`endif
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default: begin
            state_d   = S_FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADR:  state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   if (memready) state_d = S_MEMWB;
      S_MEMWR:   if (memready) state_d = S_FETCH;
      S_EXECUTE: begin
        // A bad funct skips writeback entirely so the register file is untouched.
        if (funct_ok) begin
          state_d = S_ALUWB;
        end else begin
          state_d   = S_FETCH;
          illegal_d = 1'b1;
        end
      end
      S_ADDIEX:  state_d = S_ADDIWB;
      default:   state_d = S_FETCH;
    endcase
  end

  always_comb begin
    memreq     = 1'b0;
    pcen       = 1'b0;
    iord       = 1'b0;
    irwrite    = 1'b0;
    memwrite   = 1'b0;
    regwrite   = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    alucontrol = 3'b000;
    case (state_q)
      S_FETCH: begin
        memreq     = 1'b1;
        alusrcb    = 2'b01;
        alucontrol = ALU_ADD;
        irwrite    = memready;
        pcen       = memready;
      end
      S_DECODE: begin
        alusrcb    = 2'b11;
        alucontrol = ALU_ADD;
      end
      S_MEMADR: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        alucontrol = ALU_ADD;
      end
      S_MEMRD: begin
        memreq = 1'b1;
        iord   = 1'b1;
      end
      S_MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
      end
      S_MEMWR: begin
        memreq   = 1'b1;
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      S_EXECUTE: begin
        alusrca    = 1'b1;
        alucontrol = funct_ac;
      end
      S_ALUWB: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
      end
      S_BRANCH: begin
        alusrca    = 1'b1;
        alucontrol = ALU_SUB;
        pcsrc      = 2'b01;
`ifdef MIPS_MC_BNE_EN
        pcen       = (op == OP_BNE) ? ~zero : zero;
`else
        pcen       = zero;
`endif
      end
      S_ADDIEX: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        alucontrol = ALU_ADD;
      end
      S_ADDIWB:  regwrite = 1'b1;
      S_JUMP: begin
        pcsrc = 2'b10;
        pcen  = 1'b1;
      end
      default: ;
    endcase
    // Architectural writes are suppressed while reset is held.
    if (!reset) begin
      pcen     = 1'b0;
      irwrite  = 1'b0;
      memwrite = 1'b0;
      regwrite = 1'b0;
    end
  end

  assign state   = state_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_mips_mc_controller.sv
// Directed bench for mips_mc_controller: the driver queues hand-computed
// per-cycle expectations, a negedge monitor pops and compares them.
module tb_mips_mc_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       memready;
  logic       memreq, pcen, iord, irwrite, memwrite, regwrite, regdst, memtoreg, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state;
  logic       illegal;

  mips_mc_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .memready(memready),
    .memreq(memreq), .pcen(pcen), .iord(iord), .irwrite(irwrite), .memwrite(memwrite),
    .regwrite(regwrite), .regdst(regdst), .memtoreg(memtoreg), .alusrca(alusrca),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol), .state(state),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Control word: {memreq,pcen,iord,irwrite,memwrite,regwrite,regdst,memtoreg,alusrca,alusrcb,pcsrc,alucontrol}
  localparam logic [15:0] W_FWAIT = {9'b1_0_0_0_0_0_0_0_0, 2'b01, 2'b00, 3'b010};
  localparam logic [15:0] W_FGO   = {9'b1_1_0_1_0_0_0_0_0, 2'b01, 2'b00, 3'b010};
  localparam logic [15:0] W_DEC   = {9'b0_0_0_0_0_0_0_0_0, 2'b11, 2'b00, 3'b010};
  localparam logic [15:0] W_MADR  = {9'b0_0_0_0_0_0_0_0_1, 2'b10, 2'b00, 3'b010};
  localparam logic [15:0] W_MRD   = {9'b1_0_1_0_0_0_0_0_0, 2'b00, 2'b00, 3'b000};
  localparam logic [15:0] W_MWB   = {9'b0_0_0_0_0_1_0_1_0, 2'b00, 2'b00, 3'b000};
  localparam logic [15:0] W_MWR   = {9'b1_0_1_0_1_0_0_0_0, 2'b00, 2'b00, 3'b000};
  localparam logic [15:0] W_EXE   = {9'b0_0_0_0_0_0_0_0_1, 2'b00, 2'b00, 3'b000};
  localparam logic [15:0] W_AWB   = {9'b0_0_0_0_0_1_1_0_0, 2'b00, 2'b00, 3'b000};
  localparam logic [15:0] W_BR_T  = {9'b0_1_0_0_0_0_0_0_1, 2'b00, 2'b01, 3'b110};
  localparam logic [15:0] W_BR_F  = {9'b0_0_0_0_0_0_0_0_1, 2'b00, 2'b01, 3'b110};
  localparam logic [15:0] W_AIEX  = {9'b0_0_0_0_0_0_0_0_1, 2'b10, 2'b00, 3'b010};
  localparam logic [15:0] W_AIWB  = {9'b0_0_0_0_0_1_0_0_0, 2'b00, 2'b00, 3'b000};
  localparam logic [15:0] W_JMP   = {9'b0_1_0_0_0_0_0_0_0, 2'b00, 2'b10, 3'b000};

  typedef struct {
    string      nm;
    logic [3:0] st;
    logic       ill;
    logic [15:0] w;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic ill_e  = 1'b0;

  // Drive inputs for one cycle and queue what the DUT must show during it.
  task automatic cyc(input string nm, input logic rst_n, input logic mr, input logic z,
                     input logic [3:0] st, input logic [15:0] w);
    exp_t e;
    reset    = rst_n;
    memready = mr;
    zero     = z;
    e.nm  = nm;
    e.st  = st;
    e.ill = ill_e;
    e.w   = w;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_decode();
    cyc("fetch", 1'b1, 1'b1, 1'b0, 4'd0, W_FGO);
    cyc("decode", 1'b1, 1'b1, 1'b0, 4'd1, W_DEC);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      logic [15:0] w_act;
      e = sb.pop_front();
      w_act = {memreq, pcen, iord, irwrite, memwrite, regwrite, regdst, memtoreg, alusrca,
               alusrcb, pcsrc, alucontrol};
      checks++;
      if (state !== e.st || illegal !== e.ill || w_act !== e.w) begin
        errors++;
        $display("FAIL %s: got state=%0d illegal=%b ctl=%h, expected state=%0d illegal=%b ctl=%h",
                 e.nm, state, illegal, w_act, e.st, e.ill, e.w);
      end else begin
        $display("ok   %s: state=%0d illegal=%b ctl=%h", e.nm, state, illegal, w_act);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required finish before 100000");
    $fatal(1, "watchdog");
  end

  logic [5:0] fn_tab [5];
  logic [2:0] ac_tab [5];

  initial begin
    fn_tab = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    ac_tab = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};
    reset = 1'b0; op = 6'd0; funct = 6'd0; zero = 1'b0; memready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cyc("reset_fetch_forced", 1'b0, 1'b1, 1'b0, 4'd0, W_FWAIT);

    // R-type for every supported funct
    for (int i = 0; i < 5; i++) begin
      op = 6'b000000; funct = fn_tab[i];
      fetch_decode();
      cyc("rtype_execute", 1'b1, 1'b1, 1'b0, 4'd6, W_EXE | {13'd0, ac_tab[i]});
      cyc("rtype_aluwb", 1'b1, 1'b1, 1'b0, 4'd7, W_AWB);
    end

    // lw with a fetch stall and three memory wait cycles
    op = 6'b100011;
    cyc("fetch_wait", 1'b1, 1'b0, 1'b0, 4'd0, W_FWAIT);
    fetch_decode();
    cyc("lw_memadr", 1'b1, 1'b1, 1'b0, 4'd2, W_MADR);
    repeat (3) cyc("lw_memrd_wait", 1'b1, 1'b0, 1'b0, 4'd3, W_MRD);
    cyc("lw_memrd_done", 1'b1, 1'b1, 1'b0, 4'd3, W_MRD);
    cyc("lw_memwb", 1'b1, 1'b1, 1'b0, 4'd4, W_MWB);

    // sw with one wait cycle
    op = 6'b101011;
    fetch_decode();
    cyc("sw_memadr", 1'b1, 1'b1, 1'b0, 4'd2, W_MADR);
    cyc("sw_memwr_wait", 1'b1, 1'b0, 1'b0, 4'd5, W_MWR);
    cyc("sw_memwr_done", 1'b1, 1'b1, 1'b0, 4'd5, W_MWR);

    // beq taken then not taken
    op = 6'b000100;
    fetch_decode();
    cyc("beq_taken", 1'b1, 1'b1, 1'b1, 4'd8, W_BR_T);
    fetch_decode();
    cyc("beq_not_taken", 1'b1, 1'b1, 1'b0, 4'd8, W_BR_F);

    op = 6'b001000;
    fetch_decode();
    cyc("addi_ex", 1'b1, 1'b1, 1'b0, 4'd9, W_AIEX);
    cyc("addi_wb", 1'b1, 1'b1, 1'b0, 4'd10, W_AIWB);

    op = 6'b000010;
    fetch_decode();
    cyc("jump", 1'b1, 1'b1, 1'b0, 4'd11, W_JMP);

    // Illegal opcode; flag then sticks through a following add
    op = 6'b111111;
    fetch_decode();
    ill_e = 1'b1;
    op = 6'b000000; funct = 6'b100000;
    fetch_decode();
    cyc("add_after_illegal_exec", 1'b1, 1'b1, 1'b0, 4'd6, W_EXE | 16'd2);
    cyc("add_after_illegal_wb", 1'b1, 1'b1, 1'b0, 4'd7, W_AWB);

    // Reset for two cycles while stalled in MEMRD
    op = 6'b100011;
    fetch_decode();
    cyc("lw_memadr", 1'b1, 1'b1, 1'b0, 4'd2, W_MADR);
    cyc("lw_memrd_wait", 1'b1, 1'b0, 1'b0, 4'd3, W_MRD);
    cyc("reset_in_memrd", 1'b0, 1'b0, 1'b0, 4'd3, W_MRD);
    ill_e = 1'b0;
    cyc("reset_to_fetch", 1'b0, 1'b1, 1'b0, 4'd0, W_FWAIT);

    // Unsupported funct: no writeback, illegal set
    op = 6'b000000; funct = 6'b000000;
    fetch_decode();
    cyc("badfunct_exec", 1'b1, 1'b1, 1'b0, 4'd6, W_EXE);
    ill_e = 1'b1;
    cyc("badfunct_back_to_fetch", 1'b1, 1'b0, 1'b0, 4'd0, W_FWAIT);
    cyc("reset_clears", 1'b0, 1'b1, 1'b0, 4'd0, W_FWAIT);
    ill_e = 1'b0;

    op = 6'b000101;
    fetch_decode();
`ifdef MIPS_MC_BNE_EN
    cyc("bne_taken", 1'b1, 1'b1, 1'b0, 4'd8, W_BR_T);
    fetch_decode();
    cyc("bne_not_taken", 1'b1, 1'b1, 1'b1, 4'd8, W_BR_F);
`else
    ill_e = 1'b1;
    cyc("bne_illegal", 1'b1, 1'b0, 1'b0, 4'd0, W_FWAIT);
`endif

    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_mc_controller.md
MIPS_MC_CONTROLLER -- requirements
Module: mips_mc_controller

Interface
REQ-001 clk  input  1  Single clock; all state updates on its rising edge.
REQ-002 reset  input  1  Synchronous, active-low reset (0 = reset), sampled on rising clk.
REQ-003 op  input  6  Opcode, instr[31:26], from the instruction register.
REQ-004 funct  input  6  Function field, instr[5:0].
REQ-005 zero  input  1  ALU zero flag.
REQ-006 memready  input  1  Memory completion; the current access finishes in any cycle where memreq=1 and memready=1.
REQ-007 memreq  output  1  Memory access request, asserted in FETCH, MEMRD and MEMWR.
REQ-008 outputs, all 1 bit: pcen, iord, irwrite, memwrite, regwrite, regdst, memtoreg, alusrca  Datapath enables and mux selects.
REQ-009 alusrcb  output  2  ALU B-input select: 00 reg, 01 constant 4, 10 signimm, 11 signimm<<2.
REQ-010 pcsrc  output  2  PC source select: 00 ALU result, 01 ALUOut register, 10 jump target.
REQ-011 alucontrol  output  3  ALU function: 010 add, 110 sub, 000 and, 001 or, 111 slt.
REQ-012 state  output  4  Current state encoding, for debug.
REQ-013 illegal  output  1  Sticky flag; set on an unsupported opcode or funct.

Function
REQ-014 FSM states and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11; codes 12-15 are unused.
REQ-015 FETCH: memreq=1, iord=0, alusrca=0, alusrcb=01, alucontrol=add, pcsrc=00.
REQ-016 FETCH: irwrite and pcen assert only in the cycle memready=1; the FSM stays in FETCH while memready=0.
REQ-017 FETCH -> DECODE on memready=1.
REQ-018 DECODE: alusrca=0, alusrcb=11, alucontrol=add; this computes the branch target.
REQ-019 DECODE next state by op: 100011/101011 -> MEMADR, 000000 -> EXECUTE, 000100 -> BRANCH, 001000 -> ADDIEX, 000010 -> JUMP, any other -> FETCH with illegal set.
REQ-020 MEMADR: alusrca=1, alusrcb=10, alucontrol=add; next state MEMRD for lw, MEMWR for sw.
REQ-021 MEMRD: memreq=1, iord=1; holds until memready=1, then -> MEMWB.
REQ-022 MEMWB: regwrite=1, regdst=0, memtoreg=1; next FETCH.
REQ-023 MEMWR: memreq=1, iord=1, memwrite=1; holds until memready=1, then -> FETCH.
REQ-024 EXECUTE: alusrca=1, alusrcb=00; alucontrol decoded from funct (100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt); next ALUWB.
REQ-025 ALUWB: regwrite=1, regdst=1, memtoreg=0; next FETCH.
REQ-026 Unsupported funct in EXECUTE: illegal is set and ALUWB is replaced by FETCH, with no regwrite.
REQ-027 BRANCH: alusrca=1, alusrcb=00, alucontrol=sub, pcsrc=01, pcen=zero; next FETCH.
REQ-028 ADDIEX: alusrca=1, alusrcb=10, alucontrol=add; next ADDIWB.
REQ-029 ADDIWB: regwrite=1, regdst=0, memtoreg=0; next FETCH.
REQ-030 JUMP: pcsrc=10, pcen=1; next FETCH.
REQ-031 Enables not listed for a state are 0; selects not listed are 0.
REQ-032 Latency with memready held at 1: j and beq 3 cycles; R-type, addi and sw 4 cycles; lw 5 cycles.
REQ-033 The FSM never leaves a memory state without memready=1; memready is ignored when memreq=0.
REQ-034 Unused state codes recover to FETCH on the next clock, with every output at 0 meanwhile.

Reset
REQ-035 With reset=0 at a rising edge, the next state is FETCH and illegal=0, regardless of the current state, including MEMRD/MEMWR mid-access.
REQ-036 During reset cycles, pcen, irwrite, memwrite and regwrite are forced to 0.
REQ-037 After reset deasserts, the first fetch begins in the following cycle.

Configuration
REQ-038 Macro MIPS_MC_BNE_EN defined: op 000101 (bne) decodes to BRANCH with pcen=~zero; otherwise identical to beq.
REQ-039 Macro MIPS_MC_BNE_EN undefined: op 000101 is illegal per REQ-019.

Verification
REQ-040 Reset: reset=0 for 2 cycles while in MEMRD -> state=0, illegal=0, memwrite=0, regwrite=0.
REQ-041 add, op=000000, funct=100000, memready=1 -> states 0,1,6,7,0; alucontrol=010 in state 6; regwrite=1 and regdst=1 only in state 7.
REQ-042 lw, op=100011, memready low for 3 cycles in MEMRD -> stays in state 3 for 3 cycles, then state 4 with regwrite=1 and memtoreg=1; 8 cycles total.
REQ-043 beq, op=000100: zero=1 -> pcen=1 with pcsrc=01 in state 8; zero=0 -> pcen=0.
REQ-044 Illegal opcode op=111111 -> DECODE returns to FETCH, illegal=1 holds through subsequent instructions until reset=0.
REQ-045 bne, op=000101, zero=0: with MIPS_MC_BNE_EN -> pcen=1 in state 8; without it -> illegal=1.
